// File: rtl/rnd_top_module_if.sv
// Symbol-generator handshake bundle: start/seed towards the generator,
// done pulse and current 2-bit symbol back to the consumer.
interface rnd_top_module_if #(
    parameter int REG_WIDTH = 6
);
    logic                 start_rnd;
    logic [REG_WIDTH-1:0] seed;
    logic                 done_rnd;
    logic [1:0]           x_out;

    modport master (
        output start_rnd,
        output seed,
        input  done_rnd,
        input  x_out
    );

    modport slave (
        input  start_rnd,
        input  seed,
        output done_rnd,
        output x_out
    );
endinterface

// File: rtl/rnd_top_module.sv
// Seeded 2-bit pseudo-random symbol generator: controller FSM sequencing a
// Fibonacci LFSR and a symbol counter; emits 2^CNT_WIDTH symbols per start.

module rnd_ctrl (
    input  logic clk,
    input  logic rst,
    input  logic start_rnd,
    input  logic cnt_last,
    output logic load,
    output logic step,
    output logic done_rnd
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_reg;
    state_t state_next;
    logic   done_reg;

    always_comb begin
        state_next = state_reg;
        load       = 1'b0;
        step       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start_rnd) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (cnt_last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // done is registered from the next state so it is high exactly while in DONE
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= IDLE;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            done_reg  <= (state_next == DONE);
        end
    end

    assign done_rnd = done_reg;
endmodule

module rnd_datapath #(
    parameter int REG_WIDTH = 6,
    parameter int CNT_WIDTH = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 step,
    input  logic [REG_WIDTH-1:0] seed,
    output logic                 cnt_last,
    output logic [1:0]           x_out
);
    logic [REG_WIDTH-1:0] lfsr_reg;
    logic [REG_WIDTH-1:0] lfsr_next;
    logic [REG_WIDTH-1:0] lfsr_shift;
    logic [REG_WIDTH-1:0] seed_safe;
    logic [CNT_WIDTH-1:0] cnt_reg;
    logic [CNT_WIDTH-1:0] cnt_next;
    logic                 fb;

    // top-two-bit tap gives x^6+x^5+1 (maximal length) at the default width
    assign fb            = lfsr_reg[REG_WIDTH-1] ^ lfsr_reg[REG_WIDTH-2];
    assign lfsr_shift[0] = fb;

    generate
        for (genvar gi = 1; gi < REG_WIDTH; gi++) begin : g_shift
            assign lfsr_shift[gi] = lfsr_reg[gi-1];
        end
    endgenerate

    // an all-zero LFSR would lock up, so a zero seed is replaced by 1
    assign seed_safe = (seed == '0) ? {{(REG_WIDTH-1){1'b0}}, 1'b1} : seed;

    always_comb begin
        lfsr_next = lfsr_reg;
        cnt_next  = cnt_reg;
        if (load) begin
            lfsr_next = seed_safe;
            cnt_next  = '0;
        end else if (step) begin
            lfsr_next = lfsr_shift;
            cnt_next  = cnt_reg + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            lfsr_reg <= '0;
            cnt_reg  <= '0;
        end else begin
            lfsr_reg <= lfsr_next;
            cnt_reg  <= cnt_next;
        end
    end

    assign cnt_last = &cnt_reg;
    assign x_out    = lfsr_reg[1:0];
endmodule

module rnd_top_module #(
    parameter int REG_WIDTH = 6,
    parameter int CNT_WIDTH = 3
) (
    input  logic              clk,
    input  logic              rst,
    rnd_top_module_if.slave   bus
);
    logic load;
    logic step;
    logic cnt_last;
    logic done;

    rnd_ctrl u_ctrl (
        .clk       (clk),
        .rst       (rst),
        .start_rnd (bus.start_rnd),
        .cnt_last  (cnt_last),
        .load      (load),
        .step      (step),
        .done_rnd  (done)
    );

    rnd_datapath #(
        .REG_WIDTH (REG_WIDTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_dp (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .step     (step),
        .seed     (bus.seed),
        .cnt_last (cnt_last),
        .x_out    (bus.x_out)
    );

    assign bus.done_rnd = done;
endmodule

// File: tb/tb_rnd_top_module.sv
// Bench for rnd_top_module: directed scenarios plus random traffic, all
// checked against a countdown-based reference model of the generator.
module tb_rnd_top_module;
    logic clk;
    logic rst;

    rnd_top_module_if #(.REG_WIDTH(6)) bus ();

    rnd_top_module #(
        .REG_WIDTH (6),
        .CNT_WIDTH (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;
    int done_cyc[$];

    // reference model: lfsr value, remaining RUN edges, pending done flag
    logic [5:0] m_lfsr = 6'd0;
    int         m_left = 0;
    bit         m_done = 1'b0;

    logic [1:0] sym [0:7];
    logic [1:0] nom_exp  [0:7] = '{2'd3, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
    logic [1:0] zero_exp [0:7] = '{2'd1, 2'd2, 2'd0, 2'd0, 2'd0, 2'd1, 2'd3, 2'd2};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [5:0] lfsr_adv(input logic [5:0] v);
        int fb;
        fb = ((int'(v) / 32) + (int'(v) / 16)) % 2;
        return 6'((int'(v) * 2) % 64 + fb);
    endfunction

    task automatic model_edge(input bit r, input bit s, input logic [5:0] sd);
        if (!r) begin
            m_lfsr = 6'd0;
            m_left = 0;
            m_done = 1'b0;
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (m_left > 0) begin
            m_lfsr = lfsr_adv(m_lfsr);
            m_left--;
            if (m_left == 0) m_done = 1'b1;
        end else if (s) begin
            m_lfsr = (sd == 6'd0) ? 6'd1 : sd;
            m_left = 8;
        end
    endtask

    task automatic tick(input bit r, input bit s, input logic [5:0] sd);
        rst           = r;
        bus.start_rnd = s;
        bus.seed      = sd;
        @(posedge clk);
        cyc++;
        model_edge(r, s, sd);
        #1;
        chk("x_out", 32'(bus.x_out), 32'(m_lfsr[1:0]));
        chk("done_rnd", 32'(bus.done_rnd), 32'(m_done));
        if (bus.done_rnd === 1'b1) done_cyc.push_back(cyc);
    endtask

    // start pulse at symbol 0, optional second pulse at symbol restart_at
    task automatic run8(input logic [5:0] sd, input int restart_at, input logic [5:0] sd2);
        for (int i = 0; i < 8; i++) begin
            tick(1'b1, (i == 0) || (i == restart_at), (i == 0) ? sd : sd2);
            sym[i] = bus.x_out;
        end
    endtask

    initial begin
        int gap;
        rst           = 1'b0;
        bus.start_rnd = 1'b0;
        bus.seed      = 6'd0;

        // reset held with start asserted
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b1, 6'd7);
            chk("rst_x", 32'(bus.x_out), 32'd0);
            chk("rst_done", 32'(bus.done_rnd), 32'd0);
        end
        for (int i = 0; i < 2; i++) begin
            tick(1'b1, 1'b0, 6'd7);
            chk("post_rst_idle", 32'(bus.x_out), 32'd0);
        end
        $display("reset: x_out=%b done=%b", bus.x_out, bus.done_rnd);

        // nominal run
        done_cyc.delete();
        run8(6'b000111, -1, 6'd0);
        for (int i = 0; i < 8; i++) chk("nom_sym", 32'(sym[i]), 32'(nom_exp[i]));
        tick(1'b1, 1'b0, 6'd0);
        chk("nom_final_x", 32'(bus.x_out), 32'd1);
        chk("nom_done", 32'(bus.done_rnd), 32'd1);
        tick(1'b1, 1'b0, 6'd0);
        chk("nom_done_1cyc", 32'(bus.done_rnd), 32'd0);
        tick(1'b1, 1'b0, 6'd0);
        chk("nom_idle_hold", 32'(bus.x_out), 32'd1);
        $display("nominal run: seed=07 final x_out=%b dones=%0d", bus.x_out, done_cyc.size());

        // zero seed
        run8(6'd0, -1, 6'd0);
        for (int i = 0; i < 8; i++) chk("zero_sym", 32'(sym[i]), 32'(zero_exp[i]));
        tick(1'b1, 1'b0, 6'd0);
        chk("zero_done", 32'(bus.done_rnd), 32'd1);
        tick(1'b1, 1'b0, 6'd0);
        $display("zero seed run: first symbol=%b", sym[0]);

        // start pulse while busy must be ignored
        run8(6'b000111, 3, 6'h2A);
        for (int i = 0; i < 8; i++) chk("busy_sym", 32'(sym[i]), 32'(nom_exp[i]));
        tick(1'b1, 1'b0, 6'd0);
        chk("busy_done", 32'(bus.done_rnd), 32'd1);
        chk("busy_final_x", 32'(bus.x_out), 32'd1);
        tick(1'b1, 1'b0, 6'd0);
        tick(1'b1, 1'b0, 6'd0);
        $display("start-while-busy run: final x_out=%b", bus.x_out);

        // back-to-back runs
        done_cyc.delete();
        run8(6'b000111, -1, 6'd0);
        tick(1'b1, 1'b0, 6'd0);
        tick(1'b1, 1'b0, 6'd0);
        run8(6'h15, -1, 6'd0);
        tick(1'b1, 1'b0, 6'd0);
        tick(1'b1, 1'b0, 6'd0);
        gap = (done_cyc.size() >= 2) ? (done_cyc[1] - done_cyc[0]) : 0;
        chk("b2b_count", 32'(done_cyc.size()), 32'd2);
        chk("b2b_gap", 32'(gap), 32'd10);
        $display("back-to-back runs: done gap=%0d cycles", gap);

        // reset in the middle of a run
        done_cyc.delete();
        tick(1'b1, 1'b1, 6'h2C);
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 6'd0);
        tick(1'b0, 1'b0, 6'd0);
        chk("abort_x", 32'(bus.x_out), 32'd0);
        chk("abort_done", 32'(bus.done_rnd), 32'd0);
        for (int i = 0; i < 12; i++) tick(1'b1, 1'b0, 6'd0);
        chk("abort_nodone", 32'(done_cyc.size()), 32'd0);
        $display("mid-run reset: dones after abort=%0d", done_cyc.size());

        // random traffic
        done_cyc.delete();
        for (int i = 0; i < 600; i++) begin
            tick(($urandom_range(0, 59) != 0), ($urandom_range(0, 3) == 0), 6'($urandom));
        end
        $display("random traffic: 600 cycles, %0d done pulses", done_cyc.size());

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/rnd_top_module.md
Name: rnd_top_module

Overview:
- Seeded pseudo-random 2-bit symbol generator built from a controller FSM, a REG_WIDTH-bit Fibonacci LFSR and a CNT_WIDTH-bit symbol counter.
- A one-cycle start_rnd pulse loads the seed. The block then emits 2^CNT_WIDTH consecutive 2-bit symbols on x_out, one per clock, and pulses done_rnd.
- It is the random source feeding the hash-generator datapath.

Parameters:
- REG_WIDTH, default 6: LFSR width; seed width.
- CNT_WIDTH, default 3: symbol counter width; symbols per run = 2^CNT_WIDTH (8 at default).

Ports:
- clk  input  1: system clock; all state updates on the rising edge.
- rst  input  1: synchronous, active-low reset.
- start_rnd  input  1: start request, sampled only in IDLE.
- seed  input  REG_WIDTH: initial LFSR value, captured on an accepted start.
- done_rnd  output  1: registered one-cycle completion pulse.
- x_out  output  2: current symbol, always equal to lfsr[1:0].

Behaviour:
- Reset (rst==0 at a clock edge): state=IDLE, lfsr=0, cnt=0, done_rnd=0, so x_out=00. Reset overrides everything, including mid-run.
- LFSR step: lfsr <= {lfsr[REG_WIDTH-2:0], fb}. At default, fb = lfsr[5]^lfsr[4] (x^6+x^5+1, maximal length). For other widths, fb = XOR of the top two bits.
- Seed load: lfsr <= seed. If seed==0, load 1 instead to avoid LFSR lockup.
- FSM states IDLE, RUN, DONE:
  - IDLE: if start_rnd==1, load seed, cnt<=0, go to RUN. Otherwise hold lfsr and cnt.
  - RUN: each edge steps the LFSR and increments cnt. When cnt == 2^CNT_WIDTH-1 at that edge, step once more, cnt wraps to 0, go to DONE.
  - DONE: done_rnd=1 for exactly this cycle, lfsr holds, next state IDLE.
- done_rnd is high only in DONE; it is 0 in every other state.
- Latency: start sampled at edge k.
  - Symbols 0..2^CNT_WIDTH-1 appear on x_out in the cycles following edges k..k+2^CNT_WIDTH-1.
  - done_rnd is high in the cycle following edge k+2^CNT_WIDTH (edge k+8 at default).
- start_rnd while in RUN or DONE is ignored; there is no queuing or restart.
- A start asserted in the cycle immediately after DONE (i.e. in IDLE) is accepted normally.
- A start held high for several cycles starts one run. If it is still high when the FSM returns to IDLE, a new run starts.
- seed is don't-care except at the accepting edge.
- In IDLE after a run, x_out keeps showing the final lfsr[1:0].
- Implementation: separate controller and datapath (LFSR plus counter) submodules under the top module.

Test Plan:
- Reset: hold rst=0 for 3 cycles with start_rnd=1 -> x_out=00, done_rnd=0, state stays IDLE; after release with start_rnd=0, still idle.
- Nominal run, seed=6'b000111, one-cycle start pulse:
  - x_out over the 8 RUN cycles = 11,10,00,01,10,00,01,10.
  - Next cycle: lfsr=100101, x_out=01, done_rnd=1 for exactly one cycle.
  - Then IDLE with x_out held at 01.
- Zero seed: seed=0, start -> first symbol 01 (lfsr=000001). Sequence follows from 000001 and never sticks at 0. done_rnd after 8 symbols.
- Start ignored while busy: pulse start_rnd again in RUN cycle 3 with a different seed -> sequence and done timing identical to the nominal run.
- Back-to-back runs: start_rnd pulse in the first IDLE cycle after done_rnd -> new run from the new seed; the second done_rnd comes exactly 10 cycles after the first.
- Reset mid-run: drop rst at RUN cycle 4 -> next cycle x_out=00, done_rnd=0, no done pulse is ever produced for the aborted run.
